// File: rtl/sprite_hit_decoder.sv
// Sprite hit decoder: 4-bit sprite index stream to 14-bit held activity vector.
// Optional SPRITE_RETRIGGER_EN: a hit on a lit sprite reloads its hold counter.
module sprite_hit_decoder #(
  parameter int HOLD_FRAMES = 12,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_valid,
  input  logic [3:0]  sel_index,
  output logic        sel_ready,
  input  logic        frame_tick,
  output logic [13:0] sprites,
  output logic [3:0]  active_count,
  output logic        bad_index
);

  localparam int N = 14;
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [N];
  logic [CNT_W-1:0] cnt_nxt [N];
  logic [N-1:0]     hit;
  logic [N-1:0]     lit_nxt;
  logic [3:0]       pop;
  logic             accept;
  logic             bad_nxt;

  assign sel_ready = !frame_tick;
  assign accept    = sel_valid && sel_ready;
  assign bad_nxt   = accept && (sel_index == 4'd15);

  // Decode the accepted index into a per-sprite load strobe.
  always_comb begin
    hit = '0;
    for (int k = 0; k < N; k++) begin
      hit[k] = accept && (sel_index == 4'(k + 1));
    end
  end

  // Next counter values: frame tick decrements, otherwise a hit loads.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cnt_nxt[k] = cnt[k];
      if (frame_tick) begin
        if (cnt[k] != '0) cnt_nxt[k] = cnt[k] - ONE;
      end else if (hit[k]) begin
`ifdef SPRITE_RETRIGGER_EN
        cnt_nxt[k] = HOLD;
`else
        if (cnt[k] == '0) cnt_nxt[k] = HOLD;
`endif
      end
      lit_nxt[k] = (cnt_nxt[k] != '0);
    end
  end

  // Population count of the registered sprite vector.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) begin
      pop = pop + 4'(sprites[k]);
    end
  end

  // Counter, sprite, count and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt[k] <= '0;
      sprites      <= '0;
      active_count <= '0;
      bad_index    <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++) cnt[k] <= cnt_nxt[k];
      sprites      <= lit_nxt;
      active_count <= pop;
      bad_index    <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_hit_decoder.sv
// Bench for sprite_hit_decoder: directed pins plus randomized stimulus
// against a remaining-frames model of every sprite.
module tb_sprite_hit_decoder;

  localparam int HOLD = 3;
`ifdef SPRITE_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic        clk = 0;
  logic        rst_n;
  logic        sel_valid;
  logic [3:0]  sel_index;
  logic        sel_ready;
  logic        frame_tick;
  logic [13:0] sprites;
  logic [3:0]  active_count;
  logic        bad_index;

  int checks = 0;
  int errors = 0;

  sprite_hit_decoder #(.HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sel_valid(sel_valid),
    .sel_index(sel_index),
    .sel_ready(sel_ready),
    .frame_tick(frame_tick),
    .sprites(sprites),
    .active_count(active_count),
    .bad_index(bad_index)
  );

  always #5 clk = ~clk;

  // Model: frames each sprite still has to stay lit.
  int        rem [14];
  bit [13:0] m_spr;
  int        m_cnt;
  bit        m_bad;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (rem[k]) rem[k] = 0;
      m_spr = '0;
      m_cnt = 0;
      m_bad = 0;
    end else begin
      int idx;
      bit acc;
      idx = int'(sel_index);
      acc = sel_valid && !frame_tick;
      m_cnt = $countones(m_spr);
      if (frame_tick) begin
        foreach (rem[k]) if (rem[k] > 0) rem[k] = rem[k] - 1;
      end else if (acc && idx >= 1 && idx <= 14) begin
        if (rem[idx-1] == 0 || RETRIG) rem[idx-1] = HOLD;
      end
      m_bad = acc && idx == 15;
      foreach (rem[k]) m_spr[k] = rem[k] > 0;
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("sprites", int'(sprites), int'(m_spr));
    chk("active_count", int'(active_count), m_cnt);
    chk("bad_index", int'(bad_index), int'(m_bad));
    chk("sel_ready", int'(sel_ready), int'(!frame_tick));
  end

  // Apply inputs for one edge; returns 1 time unit after that edge.
  task automatic drive(bit v, int i, bit ft);
    sel_valid  = v;
    sel_index  = 4'(i);
    frame_tick = ft;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit pend;
    rst_n = 0;
    sel_valid = 0;
    sel_index = 0;
    frame_tick = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    #1;
    chk("rst_sprites", int'(sprites), 0);
    chk("rst_active", int'(active_count), 0);
    chk("rst_bad", int'(bad_index), 0);
    chk("rst_ready", int'(sel_ready), 1);

    // Single hit on index 5 held for three ticks.
    drive(1, 5, 0);
    chk("hit5", int'(sprites), 'h0010);
    drive(0, 0, 0);
    chk("hit5_cnt", int'(active_count), 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("hit5_t2", int'(sprites), 'h0010);
    drive(0, 0, 1);
    chk("hit5_t3", int'(sprites), 0);
    chk("hit5_t3_cnt", int'(active_count), 1);
    drive(0, 0, 0);
    chk("hit5_cnt0", int'(active_count), 0);

    // Collision with frame tick, then illegal and empty indices.
    sel_valid = 1;
    sel_index = 2;
    frame_tick = 1;
    #1 chk("coll_ready", int'(sel_ready), 0);
    @(posedge clk);
    #1 chk("coll_noload", int'(sprites), 0);
    drive(1, 2, 0);
    chk("coll_load", int'(sprites), 'h0002);
    drive(1, 15, 0);
    chk("bad_pulse", int'(bad_index), 1);
    chk("bad_keep", int'(sprites), 'h0002);
    drive(1, 0, 0);
    chk("bad_end", int'(bad_index), 0);
    chk("zero_keep", int'(sprites), 'h0002);
    repeat (3) drive(0, 0, 1);
    chk("coll_clear", int'(sprites), 0);

    // Retrigger on index 14.
    drive(1, 14, 0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(1, 14, 0);
    drive(0, 0, 1);
    chk("retrig_t3", int'(sprites[13]), int'(RETRIG));
    drive(0, 0, 1);
    chk("retrig_t4", int'(sprites[13]), int'(RETRIG));
    drive(0, 0, 1);
    chk("retrig_t5", int'(sprites[13]), 0);

    // All sprites on consecutive cycles, then drain with extra ticks.
    for (int i = 1; i <= 14; i++) drive(1, i, 0);
    chk("all_spr", int'(sprites), 'h3FFF);
    drive(0, 0, 0);
    chk("all_cnt", int'(active_count), 14);
    for (int t = 0; t < 6; t++) begin
      drive(0, 0, 1);
      drive(1, 0, 0);
    end
    chk("all_drain", int'(sprites), 0);
    chk("all_cnt0", int'(active_count), 0);

    // Asynchronous reset in the middle of a hold.
    drive(1, 3, 0);
    drive(1, 7, 0);
    drive(0, 0, 0);
    chk("mid_cnt", int'(active_count), 2);
    #2 rst_n = 0;
    #1;
    chk("mid_spr", int'(sprites), 0);
    chk("mid_cnt0", int'(active_count), 0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(0, 0, 0);
    drive(0, 0, 1);
    chk("mid_norelight", int'(sprites), 0);

    // Randomized traffic; a stalled hit is held until accepted.
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      bit ft;
      ft = ($urandom_range(0, 3) == 0);
      if (!pend) begin
        sel_valid = ($urandom_range(0, 2) != 0);
        sel_index = 4'($urandom_range(0, 15));
      end
      pend = sel_valid && ft;
      drive(sel_valid, int'(sel_index), ft);
    end
    drive(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
